// File: rtl/pcie_feature_csr_regs.sv
// MMIO register slave for the PCIe feature region: DFH, SCRATCHPAD, TESTPAD
// and an FLR completion counter, with a small FSM sequencing Function Level Reset.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | accepting requests; flr_req moves to DRAIN
// DRAIN | request side closed; wait for the outstanding response to leave
// CLEAR | wipe FLR-volatile registers, bump the FLR counter
// ACK   | one-cycle flr_ack pulse, then back to IDLE
module pcie_feature_csr_regs #(
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int unsigned WINDOW_BYTES = 4096,
  parameter logic [63:0] DFH_VALUE    = 64'h3000_0000_1000_0020,
  parameter int          TAG_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  logic [63:0]      req_wdata,
  input  logic [7:0]       req_wstrb,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_write,
  output logic [63:0]      rsp_rdata,
  output logic             rsp_error,
  output logic [TAG_W-1:0] rsp_tag,
  input  logic             flr_req,
  output logic             flr_ack
);

  localparam logic [31:0] OFF_DFH     = 32'h0000_0000;
  localparam logic [31:0] OFF_SCRATCH = 32'h0000_0008;
  localparam logic [31:0] OFF_TESTPAD = 32'h0000_0028;
  localparam logic [31:0] OFF_FLRCNT  = 32'h0000_0030;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [63:0] scratchpad;
  logic [63:0] testpad;
  logic [15:0] flr_count;

  logic [31:0] offset;
  logic        in_window;
  logic        dec_err;
  logic        accept;
  logic        rsp_free;
  logic [63:0] rd_data;

  function automatic logic [63:0] byte_merge(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // Address decode: subtraction-based window check avoids overflow at the top of the map
  always_comb begin
    offset    = req_addr - BASE_ADDR;
    in_window = (req_addr >= BASE_ADDR) && (offset < 32'(WINDOW_BYTES));
    dec_err   = !in_window || (req_addr[2:0] != 3'b000);
  end

  // Read data mux; unmapped and errored offsets read as zero
  always_comb begin
    rd_data = '0;
    if (!dec_err) begin
      case (offset)
        OFF_DFH:     rd_data = DFH_VALUE;
        OFF_SCRATCH: rd_data = scratchpad;
        OFF_TESTPAD: rd_data = testpad;
        OFF_FLRCNT:  rd_data = {48'd0, flr_count};
        default:     rd_data = '0;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic; flr_req outside IDLE is dropped on purpose
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (flr_req) state_nxt = DRAIN;
      DRAIN:   if (!rsp_valid || rsp_ready) state_nxt = CLEAR;
      CLEAR:   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs; ready is held low while rst is asserted so the port idles at 0
  always_comb begin
    rsp_free  = !rsp_valid || rsp_ready;
    req_ready = !rst && (state == IDLE) && !flr_req && rsp_free;
    flr_ack   = (state == ACK);
    accept    = req_valid && req_ready;
  end

  // RW registers; CLEAR never overlaps a write since ready is low outside IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      scratchpad <= '0;
      testpad    <= '0;
    end else if (state == CLEAR) begin
      scratchpad <= '0;
    end else if (accept && req_write && !dec_err) begin
      if (offset == OFF_SCRATCH) scratchpad <= byte_merge(scratchpad, req_wdata, req_wstrb);
      if (offset == OFF_TESTPAD) testpad    <= byte_merge(testpad, req_wdata, req_wstrb);
    end
  end

  // Saturating count of completed FLRs
  always_ff @(posedge clk) begin
    if (rst)                                         flr_count <= '0;
    else if (state == CLEAR && flr_count != 16'hFFFF) flr_count <= flr_count + 16'd1;
  end

  // Single-entry response register; payload only moves on accept so it holds under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      rsp_tag   <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_write <= req_write;
      rsp_rdata <= req_write ? 64'd0 : rd_data;
      rsp_error <= dec_err;
      rsp_tag   <= req_tag;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
